// File: rtl/mem_responder_if.sv
// mem_responder_if: single-word load/store bundle between CPU MEM stage and memory.
// master = CPU requester side, slave = memory responder side.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit memory slave with programmable wait states.
// Optional out-of-range detection (err, DEADBEEF read data) under `define MEM_ERR_EN.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              mem_wr;
  logic              oor;
  logic [ADDR_W-1:0] idx;

  logic [31:0] mem_q [DEPTH];

  assign idx = addr_q[ADDR_W-1:0];

`ifdef MEM_ERR_EN
  assign oor = (addr_q >= 32'(DEPTH));
`else
  // upper address bits wrap silently
  logic unused_addr;
  assign oor         = 1'b0;
  assign unused_addr = ^addr_q[31:ADDR_W];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_wr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_L == 4'd0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_L;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (oor)        rdata_d = 32'hDEADBEEF;
        else if (we_q)  mem_wr  = 1'b1;
        else            rdata_d = mem_q[idx];
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // outputs lag the FSM by one edge; busy covers the ack cycle
    ack_d  = (state_q == S_RESP);
    err_d  = ack_d & oor;
    busy_d = (state_d != S_IDLE) | ack_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_wr) mem_q[idx] <= wdata_q;
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder.
// Two instances: WAIT_CYCLES=2 (sel 0) and WAIT_CYCLES=0 (sel 1).
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_responder_if bus();
  mem_responder_if bus0();

  mem_responder #(
    .ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  mem_responder #(
    .ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  int vec = 0;
  int bad = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [2][1024];
  logic [31:0] last_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d;
    end else begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d;
    end
  endtask

  task automatic sample(input int sel, output logic ak, output logic bz,
                        output logic er, output logic [31:0] rd);
    if (sel == 0) begin
      ak = bus.ack; bz = bus.busy; er = bus.err; rd = bus.rdata;
    end else begin
      ak = bus0.ack; bz = bus0.busy; er = bus0.err; rd = bus0.rdata;
    end
  endtask

  function automatic logic is_oor(input logic [31:0] a);
    logic r;
    r = 1'b0;
`ifdef MEM_ERR_EN
    r = (a >= 32'd1024);
`endif
    return r;
  endfunction

  // expected read data / held data for one transaction, updating the model
  function automatic logic [31:0] expect_rd(input int sel, input logic w,
                                            input logic [31:0] a,
                                            input logic [31:0] d);
    logic [31:0] e;
    if (is_oor(a)) begin
      e = 32'hDEADBEEF;
    end else if (w) begin
      e = last_rd[sel];
      model[sel][a[9:0]] = d;
    end else begin
      e = model[sel][a[9:0]];
    end
    last_rd[sel] = e;
    return e;
  endfunction

  task automatic txn(input int sel, input logic w, input logic [31:0] a,
                     input logic [31:0] d);
    logic [31:0] e, rd;
    logic ak, bz, er, got, bz_ok;
    int n;
    e = expect_rd(sel, w, a, d);
    exp_q.push_back(e);
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    @(posedge clk);
    n = 0; got = 1'b0; bz_ok = 1'b1;
    ak = 1'b0; bz = 1'b0; er = 1'b0; rd = '0;
    while (!got && n < 40) begin
      #1;
      sample(sel, ak, bz, er, rd);
      if (ak) begin
        got = 1'b1;
      end else begin
        if (!bz) bz_ok = 1'b0;
        @(posedge clk);
        n++;
      end
    end
    chk("ack_seen", {31'b0, got}, 32'd1);
    chk("latency", n, (sel == 0) ? 32'd4 : 32'd2);
    chk("busy_inflight", {31'b0, bz_ok & bz}, 32'd1);
    chk("rdata_ack", rd, exp_q.pop_front());
    chk("err_ack", {31'b0, er}, {31'b0, is_oor(a)});
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    sample(sel, ak, bz, er, rd);
    chk("ack_pulse", {31'b0, ak}, 32'd0);
    chk("busy_done", {31'b0, bz}, 32'd0);
    chk("err_done", {31'b0, er}, 32'd0);
    chk("rdata_hold", rd, e);
  endtask

  initial begin
    logic [31:0] e1;
    int a1, a2;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) model[s][i] = 32'h0;
      last_rd[s] = 32'h0;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle stability
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_ack", {31'b0, bus.ack}, 32'd0);
      chk("idle_busy", {31'b0, bus.busy}, 32'd0);
      chk("idle_err", {31'b0, bus.err}, 32'd0);
      chk("idle_rdata", bus.rdata, 32'h0);
    end

    // write then read
    txn(0, 1'b1, 32'd5, 32'hCAFE0001);
    txn(0, 1'b0, 32'd5, 32'h0);

    // back-to-back reads with req held across ack
    txn(0, 1'b1, 32'd1018, 32'h0000AF01);
    txn(0, 1'b1, 32'd1019, 32'h00000B51);
    exp_q.push_back(expect_rd(0, 1'b0, 32'd1018, 32'h0));
    exp_q.push_back(expect_rd(0, 1'b0, 32'd1019, 32'h0));
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd1018, 32'h0);
    a1 = -1; a2 = -1;
    for (int k = 0; k < 30 && a2 < 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.ack) begin
        e1 = exp_q.pop_front();
        chk("b2b_rdata", bus.rdata, e1);
        if (a1 < 0) begin
          a1 = k;
          bus.addr = 32'd1019;
        end else begin
          a2 = k;
          drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
    end
    chk("b2b_gap", a2 - a1, 32'd5);
    @(posedge clk);
    #1;
    chk("b2b_idle", {31'b0, bus.busy}, 32'd0);

    // reset during WAIT of a write
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd7, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_ack", {31'b0, bus.ack}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("rst_noack", {31'b0, bus.ack}, 32'd0);
    end
    txn(0, 1'b0, 32'd7, 32'h0);

    // zero wait states
    txn(1, 1'b1, 32'd3, 32'h00003333);
    txn(1, 1'b0, 32'd3, 32'h0);

    // address beyond DEPTH
    txn(0, 1'b1, 32'd1033, 32'h000000AA);
    txn(0, 1'b0, 32'd1033, 32'h0);
    txn(0, 1'b0, 32'd9, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
